regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file: picks between ALU and load-unit writes,
// registers the winning write, and keeps a pending-destination scoreboard for hazards.
module regfile_wb_arbiter #(
    parameter int DATA_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    input  logic [REG_ADDR_LEN-1:0] req0_addr,
    input  logic [DATA_LEN-1:0]     req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [REG_ADDR_LEN-1:0] req1_addr,
    input  logic [DATA_LEN-1:0]     req1_data,
    output logic                    req1_ready,
    output logic                    rf_we,
    output logic [REG_ADDR_LEN-1:0] rf_w_addr,
    output logic [DATA_LEN-1:0]     rf_w_data,
    input  logic                    issue_valid,
    input  logic [REG_ADDR_LEN-1:0] issue_addr,
    output logic                    issue_ready,
    input  logic [REG_ADDR_LEN-1:0] chk_addr1,
    input  logic [REG_ADDR_LEN-1:0] chk_addr2,
    output logic                    chk_busy1,
    output logic                    chk_busy2
);

    localparam int NUM_REGS = 1 << REG_ADDR_LEN;
    localparam int CNT_LEN  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_LEN-1:0] CNT_MAX = CNT_LEN'(STARVE_LIMIT);

    logic [CNT_LEN-1:0]      r_starveCnt;
    logic [NUM_REGS-1:0]     r_pending;
    logic                    r_rfWe;
    logic [REG_ADDR_LEN-1:0] r_rfWAddr;
    logic [DATA_LEN-1:0]     r_rfWData;

    logic                    w_starved;
    logic                    w_grant0;
    logic                    w_grant1;
    logic                    w_issueAccept;
    logic [NUM_REGS-1:0]     w_setMask;
    logic [NUM_REGS-1:0]     w_clrMask;

    // The load unit only overrides the ALU once it has been starved long enough.
    assign w_starved     = (r_starveCnt == CNT_MAX);
    assign w_grant1      = req1_valid && (!req0_valid || w_starved);
    assign w_grant0      = req0_valid && !w_grant1;
    assign req0_ready    = w_grant0;
    assign req1_ready    = w_grant1;

    assign issue_ready   = (issue_addr == '0) || !r_pending[issue_addr];
    assign w_issueAccept = issue_valid && issue_ready;

    assign chk_busy1     = (chk_addr1 != '0) && r_pending[chk_addr1];
    assign chk_busy2     = (chk_addr2 != '0) && r_pending[chk_addr2];

    assign rf_we         = r_rfWe;
    assign rf_w_addr     = r_rfWAddr;
    assign rf_w_data     = r_rfWData;

    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        if (w_issueAccept && (issue_addr != '0))
            w_setMask[issue_addr] = 1'b1;
        if (r_rfWe)
            w_clrMask[r_rfWAddr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starveCnt <= '0;
        end else if (req1_valid && !w_grant1) begin
            if (!w_starved)
                r_starveCnt <= r_starveCnt + 1'b1;
        end else begin
            r_starveCnt <= '0;
        end
    end

    // Register-0 writes are granted but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rfWe    <= 1'b0;
            r_rfWAddr <= '0;
            r_rfWData <= '0;
        end else if (w_grant1) begin
            r_rfWe    <= (req1_addr != '0);
            r_rfWAddr <= req1_addr;
            r_rfWData <= req1_data;
        end else if (w_grant0) begin
            r_rfWe    <= (req0_addr != '0);
            r_rfWAddr <= req0_addr;
            r_rfWData <= req0_data;
        end else begin
            r_rfWe    <= 1'b0;
        end
    end

    // A new issue to a register wins over a writeback retiring that same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_clrMask) | w_setMask;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, issue_valid;
    logic [4:0]  req0_addr, req1_addr, issue_addr, chk_addr1, chk_addr2;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, issue_ready, chk_busy1, chk_busy2;
    logic        rf_we;
    logic [4:0]  rf_w_addr;
    logic [31:0] rf_w_data;

    int errCount   = 0;
    int checkCount = 0;

    int          mStarve = 0;
    bit          mPending [32];
    bit          mWe = 1'b0;
    logic [4:0]  mAddr = '0;
    logic [31:0] mData = '0;

    regfile_wb_arbiter #(.DATA_LEN(32), .REG_ADDR_LEN(5), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2)
    );

    always #5 clk = ~clk;

    // Rule-level model: load unit wins only when ALU is idle or it has waited LIMIT cycles.
    function automatic bit expGrant1();
        return req1_valid && (!req0_valid || mStarve >= LIMIT);
    endfunction

    function automatic bit expGrant0();
        return req0_valid && !expGrant1();
    endfunction

    function automatic bit expIssueReady();
        return (issue_addr == 0) || !mPending[issue_addr];
    endfunction

    function automatic bit expBusy(input logic [4:0] a);
        return (a != 0) && mPending[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mStarve <= 0;
            mWe     <= 1'b0;
            mAddr   <= '0;
            mData   <= '0;
            for (int k = 0; k < 32; k++) mPending[k] <= 1'b0;
        end else begin
            if (expGrant1()) begin
                mWe <= (req1_addr != 0); mAddr <= req1_addr; mData <= req1_data;
            end else if (expGrant0()) begin
                mWe <= (req0_addr != 0); mAddr <= req0_addr; mData <= req0_data;
            end else begin
                mWe <= 1'b0;
            end
            mStarve <= (req1_valid && !expGrant1()) ? ((mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1) : 0;
            for (int k = 1; k < 32; k++) begin
                if (issue_valid && expIssueReady() && issue_addr == k) mPending[k] <= 1'b1;
                else if (mWe && mAddr == k)                           mPending[k] <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("m_req0_ready",  req0_ready,  expGrant0());
        checkOutput("m_req1_ready",  req1_ready,  expGrant1());
        checkOutput("m_issue_ready", issue_ready, expIssueReady());
        checkOutput("m_chk_busy1",   chk_busy1,   expBusy(chk_addr1));
        checkOutput("m_chk_busy2",   chk_busy2,   expBusy(chk_addr2));
        checkOutput("m_rf_we",       rf_we,       mWe);
        checkOutput("m_rf_w_addr",   rf_w_addr,   mAddr);
        checkOutput("m_rf_w_data",   rf_w_data,   mData);
    end

    task automatic applyStimulus(input logic r0v, input logic [4:0] r0a, input logic [31:0] r0d,
                                 input logic r1v, input logic [4:0] r1a, input logic [31:0] r1d,
                                 input logic iv, input logic [4:0] ia,
                                 input logic [4:0] c1, input logic [4:0] c2);
        @(posedge clk);
        #1;
        req0_valid = r0v; req0_addr = r0a; req0_data = r0d;
        req1_valid = r1v; req1_addr = r1a; req1_data = r1d;
        issue_valid = iv; issue_addr = ia;
        chk_addr1 = c1; chk_addr2 = c2;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        issue_valid = 0; issue_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
        @(negedge clk); @(negedge clk);
        checkOutput("rst_rf_we", rf_we, 0);
        checkOutput("rst_rf_w_addr", rf_w_addr, 0);
        checkOutput("rst_rf_w_data", rf_w_data, 0);
        rst = 1'b0;

        // Single ALU write, granted immediately after reset release
        applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("single_req0_ready", req0_ready, 1);
        checkOutput("single_req1_ready", req1_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("single_rf_we", rf_we, 1);
        checkOutput("single_rf_w_addr", rf_w_addr, 5);
        checkOutput("single_rf_w_data", rf_w_data, 32'h1234);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("single_rf_we_after", rf_we, 0);

        // Both requesters busy: load unit gets every 4th grant
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 2, 32'hA0 + i, 1, 3, 32'hBEEF, 0, 0, 0, 0);
            checkOutput("fair_req1_ready", req1_ready, (i % 4 == 3) ? 1 : 0);
            checkOutput("fair_req0_ready", req0_ready, (i % 4 == 3) ? 0 : 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fair_rf_w_addr", rf_w_addr, 3);
        checkOutput("fair_rf_w_data", rf_w_data, 32'hBEEF);

        // Dropping req1_valid clears the starvation count
        applyStimulus(1, 2, 32'h1, 1, 3, 32'h33, 0, 0, 0, 0);
        applyStimulus(1, 2, 32'h2, 1, 3, 32'h33, 0, 0, 0, 0);
        applyStimulus(1, 2, 32'h3, 0, 3, 32'h33, 0, 0, 0, 0);
        applyStimulus(1, 2, 32'h4, 1, 3, 32'h33, 0, 0, 0, 0);
        checkOutput("starve_clear_req1", req1_ready, 0);
        applyStimulus(1, 2, 32'h5, 1, 3, 32'h33, 0, 0, 0, 0);
        applyStimulus(1, 2, 32'h6, 1, 3, 32'h33, 0, 0, 0, 0);
        applyStimulus(1, 2, 32'h7, 1, 3, 32'h33, 0, 0, 0, 0);
        checkOutput("starve_refill_req1", req1_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Write to register 0 is granted but suppressed
        applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        checkOutput("r0_req1_ready", req1_ready, 1);
        checkOutput("r0_chk_busy1", chk_busy1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_rf_we", rf_we, 0);

        // WAW stall on register 7 until its writeback retires
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        checkOutput("waw_first_issue", issue_ready, 1);
        checkOutput("waw_first_busy", chk_busy1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        checkOutput("waw_stall_issue", issue_ready, 0);
        checkOutput("waw_stall_busy", chk_busy1, 1);
        applyStimulus(1, 7, 32'h77, 0, 0, 0, 1, 7, 7, 0);
        checkOutput("waw_wb_issue", issue_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        checkOutput("waw_rf_we", rf_we, 1);
        checkOutput("waw_rf_w_addr", rf_w_addr, 7);
        checkOutput("waw_during_we_busy", chk_busy1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        checkOutput("waw_release_issue", issue_ready, 1);
        checkOutput("waw_release_busy", chk_busy1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        checkOutput("waw_reissued_busy2", chk_busy2, 1);

        // Issue and writeback of register 9 in the same cycle leaves it pending
        applyStimulus(1, 9, 32'h9, 0, 0, 0, 0, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        checkOutput("same_rf_w_addr", rf_w_addr, 9);
        checkOutput("same_issue_ready", issue_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        checkOutput("same_busy_after", chk_busy1, 1);

        // Same destination from both requesters is serialized
        applyStimulus(1, 12, 32'h111, 1, 12, 32'h222, 0, 0, 0, 0);
        checkOutput("ser_req0_ready", req0_ready, 1);
        checkOutput("ser_req1_ready", req1_ready, 0);
        applyStimulus(0, 0, 0, 1, 12, 32'h222, 0, 0, 0, 0);
        checkOutput("ser_req1_ready2", req1_ready, 1);
        checkOutput("ser_first_data", rf_w_data, 32'h111);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ser_second_data", rf_w_data, 32'h222);

        // Mid-cycle reset with pending bits and a transfer in flight
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 3, 4);
        applyStimulus(1, 11, 32'hCAFE, 0, 0, 0, 1, 4, 3, 4);
        applyStimulus(1, 10, 32'h55, 0, 0, 0, 0, 0, 3, 4);
        checkOutput("prerst_busy1", chk_busy1, 1);
        checkOutput("prerst_busy2", chk_busy2, 1);
        checkOutput("prerst_rf_we", rf_we, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_rf_we", rf_we, 0);
        checkOutput("midrst_rf_w_addr", rf_w_addr, 0);
        checkOutput("midrst_rf_w_data", rf_w_data, 0);
        checkOutput("midrst_busy1", chk_busy1, 0);
        checkOutput("midrst_busy2", chk_busy2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        checkOutput("postrst_rf_we", rf_we, 0);
        checkOutput("postrst_busy1", chk_busy1, 0);
        checkOutput("postrst_busy2", chk_busy2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
